multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Moore-style finite-state controller that sequences the multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut registers, single ALU) for R-format, lw, sw, beq and j. It replaces single-cycle opcode decoding with a per-instruction step sequence. It stalls on a memory-ready handshake and flags illegal opcodes. It drives every datapath enable and mux select, and feeds ALUOp to the existing ALU control.

## Interface
Parameters:
- ENABLE_JUMP, 1, 1 = opcode 6'h02 is legal (JUMP state); 0 = treated as illegal

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- Op  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target
- ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
- ALUSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- state  output  4  current state encoding, for debug

## Operation
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9. Codes 10–15 are unreachable and return to FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready, else hold.
  - DECODE→MEM_ADDR for Op 6'h23 or 6'h2B.
  - DECODE→EXECUTE for 6'h00.
  - DECODE→BRANCH for 6'h04.
  - DECODE→JUMP for 6'h02 (if ENABLE_JUMP).
  - DECODE→FETCH otherwise, with illegal_op=1.
  - MEM_ADDR→MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD→MEM_WB when mem_ready, else hold.
  - MEM_WR→FETCH when mem_ready, else hold.
  - MEM_WB, R_WB, BRANCH, JUMP→FETCH.
- Outputs (unlisted = 0):
  - FETCH: MemRead=1, ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready.
  - DECODE: ALUSrcB=11.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10.
  - MEM_RD: MemRead=1, IorD=1.
  - MEM_WB: RegWrite=1, MemtoReg=1.
  - MEM_WR: MemWrite=1, IorD=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - R_WB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
- instr_done=1 in:
  - MEM_WB, R_WB, BRANCH, JUMP;
  - MEM_WR when mem_ready;
  - DECODE when illegal.
- Op is sampled only in DECODE and MEM_ADDR; it is ignored elsewhere.

## Timing
- State is a register, updated on the clk rising edge. Outputs are combinational from state, plus mem_ready where listed.
- reset=1 at an edge forces state to FETCH on that edge, from any state, mid-instruction included. While reset=1, all outputs are forced to 0, state output included. The aborted instruction produces no writes.
- The first cycle after reset deasserts is FETCH, with outputs as specified above.
- Latency with mem_ready held 1: R 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each low cycle of mem_ready in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- While mem_ready is low in FETCH, PCWrite=IRWrite=0 and MemRead stays 1.
- mem_ready is ignored in all other states.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - state localparams;
  - ALUOp, ALUSrcB and PCSource encodings.
- The ALU control unit imports the ALUOp encodings from the same package.
- Sub-module ctrl_output_decode (state, mem_ready → control vector) is combinational. The top holds the state register and next-state logic.

## Test plan
- Reset mid-lw: assert reset while in MEM_RD → next cycle state=0, all outputs 0 during reset, FETCH outputs (MemRead=1, ALUSrcB=01) the cycle after release.
- Op=6'h00, mem_ready=1 → states 0,1,6,7,0. RegDst=RegWrite=1 only in state 7. instr_done pulses in cycle 4 only.
- Op=6'h23 with mem_ready low 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0. MemRead=IorD=1 across all three MEM_RD cycles. MemtoReg=1 in state 4.
- Op=6'h2B, then Op=6'h04 → sw: 0,1,2,5,0 with MemWrite=1 only in state 5. beq: 0,1,8 with PCWriteCond=1, ALUOp=01, PCSource=01.
- Op=6'h3F → illegal_op=1 and instr_done=1 in DECODE, then FETCH. Repeat with ENABLE_JUMP=0 and Op=6'h02 → same response. With ENABLE_JUMP=1 and Op=6'h02 → JUMP with PCWrite=1, PCSource=10.
- mem_ready=0 for 3 cycles in FETCH → state held at 0, PCWrite=IRWrite=0 for those cycles. Both are 1 in the releasing cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux encodings and the packed control vector driven to the datapath.
package mips_ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Controller states; codes 10..15 are unused and recover to StFetch
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9
  } state_e;

  // ALUOp encodings, also consumed by the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Complete set of controller outputs besides the state code
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       irWrite;
    logic       aluSrcA;
    logic       regWrite;
    logic       regDst;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic       illegalOp;
    logic       instrDone;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: maps the current state (plus mem_ready where the
// handshake gates a write, and the DECODE-time illegal flag) to the control vector.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e curState,
  input  logic   memReady,
  input  logic   opIllegal,
  output ctrl_t  ctrl
);

  // Per-state control values; anything not assigned stays deasserted
  always_comb begin
    ctrl = CTRL_NONE;
    unique case (curState)
      StFetch: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = ALUSRCB_FOUR;
        // IR and PC only capture once the instruction word has arrived
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      StDecode: begin
        ctrl.aluSrcB   = ALUSRCB_IMM_SH2;
        ctrl.illegalOp = opIllegal;
        ctrl.instrDone = opIllegal;
      end
      StMemAddr: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = ALUSRCB_IMM;
      end
      StMemRd: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      StMemWb: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memtoReg  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      StMemWr: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iorD      = 1'b1;
        ctrl.instrDone = memReady;
      end
      StExecute: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      StRWb: begin
        ctrl.regDst    = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      StBranch: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
        ctrl.instrDone   = 1'b1;
      end
      StJump: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSource  = PCSRC_JUMP;
        ctrl.instrDone = 1'b1;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS controller: state register and next-state sequencing for
// R-format, lw, sw, beq and j, with memory-ready stalls and illegal-opcode flagging.
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_e stateQ, stateD;
  logic   opIllegal;
  ctrl_t  ctrlDec;
  ctrl_t  ctrlOut;

  // Opcode legality; only meaningful while in DECODE
  always_comb begin
    opIllegal = 1'b1;
    case (Op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: opIllegal = 1'b0;
      OP_J:                           opIllegal = !ENABLE_JUMP;
      default:                        opIllegal = 1'b1;
    endcase
  end

  // Next-state sequencing; Op is only looked at in DECODE and MEM_ADDR
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StFetch: if (mem_ready) stateD = StDecode;
      StDecode: begin
        if (opIllegal) begin
          stateD = StFetch;
        end else begin
          case (Op)
            OP_LW, OP_SW: stateD = StMemAddr;
            OP_RTYPE:     stateD = StExecute;
            OP_BEQ:       stateD = StBranch;
            OP_J:         stateD = StJump;
            default:      stateD = StFetch;
          endcase
        end
      end
      StMemAddr: stateD = (Op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) stateD = StMemWb;
      StMemWr:   if (mem_ready) stateD = StFetch;
      StMemWb, StExecute, StRWb, StBranch, StJump: begin
        stateD = (stateQ == StExecute) ? StRWb : StFetch;
      end
      default:   stateD = StFetch;
    endcase
  end

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StFetch;
    end else begin
      stateQ <= stateD;
    end
  end

  ctrl_output_decode u_decode (
    .curState  (stateQ),
    .memReady  (mem_ready),
    .opIllegal (opIllegal),
    .ctrl      (ctrlDec)
  );

  // Hold every output low during reset so an aborted instruction writes nothing
  always_comb begin
    ctrlOut = reset ? CTRL_NONE : ctrlDec;
    state   = reset ? 4'd0 : stateQ;
  end

  assign PCWrite     = ctrlOut.pcWrite;
  assign PCWriteCond = ctrlOut.pcWriteCond;
  assign IorD        = ctrlOut.iorD;
  assign MemRead     = ctrlOut.memRead;
  assign MemWrite    = ctrlOut.memWrite;
  assign MemtoReg    = ctrlOut.memtoReg;
  assign IRWrite     = ctrlOut.irWrite;
  assign ALUSrcA     = ctrlOut.aluSrcA;
  assign RegWrite    = ctrlOut.regWrite;
  assign RegDst      = ctrlOut.regDst;
  assign PCSource    = ctrlOut.pcSource;
  assign ALUOp       = ctrlOut.aluOp;
  assign ALUSrcB     = ctrlOut.aluSrcB;
  assign illegal_op  = ctrlOut.illegalOp;
  assign instr_done  = ctrlOut.instrDone;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control; one instance with jump enabled and one
// without, both driven by the same inputs. Outputs are packed into one vector
// {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,
//  RegDst,PCSource,ALUOp,ALUSrcB,illegal_op,instr_done,state}.
module tb_multi_cycle_control;

  localparam logic [21:0] E_ZERO       = 22'd0;
  localparam logic [21:0] E_FETCH      = {10'b1001001000, 2'b00, 2'b00, 2'b01, 2'b00, 4'd0};
  localparam logic [21:0] E_FETCH_WAIT = {10'b0001000000, 2'b00, 2'b00, 2'b01, 2'b00, 4'd0};
  localparam logic [21:0] E_DECODE     = {10'b0000000000, 2'b00, 2'b00, 2'b11, 2'b00, 4'd1};
  localparam logic [21:0] E_DECODE_ILL = {10'b0000000000, 2'b00, 2'b00, 2'b11, 2'b11, 4'd1};
  localparam logic [21:0] E_MADDR      = {10'b0000000100, 2'b00, 2'b00, 2'b10, 2'b00, 4'd2};
  localparam logic [21:0] E_MRD        = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd3};
  localparam logic [21:0] E_MWB        = {10'b0000010010, 2'b00, 2'b00, 2'b00, 2'b01, 4'd4};
  localparam logic [21:0] E_MWR        = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b01, 4'd5};
  localparam logic [21:0] E_MWR_WAIT   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd5};
  localparam logic [21:0] E_EXEC       = {10'b0000000100, 2'b00, 2'b10, 2'b00, 2'b00, 4'd6};
  localparam logic [21:0] E_RWB        = {10'b0000000011, 2'b00, 2'b00, 2'b00, 2'b01, 4'd7};
  localparam logic [21:0] E_BR         = {10'b0100000100, 2'b01, 2'b01, 2'b00, 2'b01, 4'd8};
  localparam logic [21:0] E_JMP        = {10'b1000000000, 2'b10, 2'b00, 2'b00, 2'b01, 4'd9};

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;

  logic       pcw0, pcwc0, iord0, mrd0, mwr0, m2r0, irw0, asa0, rw0, rd0, ill0, done0;
  logic [1:0] pcs0, aop0, asb0;
  logic [3:0] st0;
  logic       pcw1, pcwc1, iord1, mrd1, mwr1, m2r1, irw1, asa1, rw1, rd1, ill1, done1;
  logic [1:0] pcs1, aop1, asb1;
  logic [3:0] st1;

  logic [21:0] obs0, obs1;
  int nCompared   = 0;
  int nMismatched = 0;

  assign obs0 = {pcw0, pcwc0, iord0, mrd0, mwr0, m2r0, irw0, asa0, rw0, rd0,
                 pcs0, aop0, asb0, ill0, done0, st0};
  assign obs1 = {pcw1, pcwc1, iord1, mrd1, mwr1, m2r1, irw1, asa1, rw1, rd1,
                 pcs1, aop1, asb1, ill1, done1, st1};

  always #5 clk = ~clk;

  multi_cycle_control #(.ENABLE_JUMP(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mrd0), .MemWrite(mwr0),
    .MemtoReg(m2r0), .IRWrite(irw0), .ALUSrcA(asa0), .RegWrite(rw0), .RegDst(rd0),
    .PCSource(pcs0), .ALUOp(aop0), .ALUSrcB(asb0), .illegal_op(ill0),
    .instr_done(done0), .state(st0)
  );

  multi_cycle_control #(.ENABLE_JUMP(1'b0)) dut_nojump (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
    .MemtoReg(m2r1), .IRWrite(irw1), .ALUSrcA(asa1), .RegWrite(rw1), .RegDst(rd1),
    .PCSource(pcs1), .ALUOp(aop1), .ALUSrcB(asb1), .illegal_op(ill1),
    .instr_done(done1), .state(st1)
  );

  // Each task starts 1 time unit after a rising edge with both DUTs in FETCH
  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; Op = 6'h00;
    @(posedge clk); #1;
    #3;
    nCompared += 2;
    if (obs0 !== E_ZERO) begin
      nMismatched++; $display("FAIL reset_hold dut got %h, expected %h", obs0, E_ZERO);
    end
    if (obs1 !== E_ZERO) begin
      nMismatched++; $display("FAIL reset_hold_nojump got %h, expected %h", obs1, E_ZERO);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    #3;
    nCompared++;
    if (obs0 !== E_FETCH_WAIT) begin
      nMismatched++; $display("FAIL reset_release got %h, expected %h", obs0, E_FETCH_WAIT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_fetch_stall();
    logic [21:0] ex [7];
    logic        mr [7];
    ex = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH, E_DECODE, E_EXEC, E_RWB};
    mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    Op = 6'h00;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #3;
      nCompared += 2;
      if (obs0 !== ex[i]) begin
        nMismatched++; $display("FAIL rtype cycle %0d got %h, expected %h", i, obs0, ex[i]);
      end
      if (obs1 !== ex[i]) begin
        nMismatched++;
        $display("FAIL rtype_nojump cycle %0d got %h, expected %h", i, obs1, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [21:0] ex [7];
    logic        mr [7];
    ex = '{E_FETCH, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MWB};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = 6'h23;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #3;
      nCompared++;
      if (obs0 !== ex[i]) begin
        nMismatched++; $display("FAIL lw cycle %0d got %h, expected %h", i, obs0, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] ex [8];
    logic        mr [8];
    logic [5:0]  op [8];
    ex = '{E_FETCH, E_DECODE, E_MADDR, E_MWR_WAIT, E_MWR, E_FETCH, E_DECODE, E_BR};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    op = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h04, 6'h04, 6'h04};
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i]; Op = op[i];
      #3;
      nCompared++;
      if (obs0 !== ex[i]) begin
        nMismatched++; $display("FAIL sw_beq cycle %0d got %h, expected %h", i, obs0, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [21:0] ex [2];
    ex = '{E_FETCH, E_DECODE_ILL};
    Op = 6'h3F; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      nCompared += 2;
      if (obs0 !== ex[i]) begin
        nMismatched++; $display("FAIL illegal cycle %0d got %h, expected %h", i, obs0, ex[i]);
      end
      if (obs1 !== ex[i]) begin
        nMismatched++;
        $display("FAIL illegal_nojump cycle %0d got %h, expected %h", i, obs1, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Jump-enabled DUT takes JUMP; jump-disabled DUT flags illegal and then
  // waits in FETCH (mem_ready low) so both land in FETCH together.
  task automatic test_jump();
    logic [21:0] ex0 [3];
    logic [21:0] ex1 [3];
    logic        mr  [3];
    ex0 = '{E_FETCH, E_DECODE, E_JMP};
    ex1 = '{E_FETCH, E_DECODE_ILL, E_FETCH_WAIT};
    mr  = '{1'b1, 1'b1, 1'b0};
    Op = 6'h02;
    for (int i = 0; i < 3; i++) begin
      mem_ready = mr[i];
      #3;
      nCompared += 2;
      if (obs0 !== ex0[i]) begin
        nMismatched++; $display("FAIL jump cycle %0d got %h, expected %h", i, obs0, ex0[i]);
      end
      if (obs1 !== ex1[i]) begin
        nMismatched++;
        $display("FAIL jump_disabled cycle %0d got %h, expected %h", i, obs1, ex1[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_lw();
    logic [21:0] ex [7];
    logic        mr [7];
    logic        rs [7];
    ex = '{E_FETCH, E_DECODE, E_MADDR, E_MRD, E_ZERO, E_ZERO, E_FETCH_WAIT};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    Op = 6'h23;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; reset = rs[i];
      #3;
      nCompared++;
      if (obs0 !== ex[i]) begin
        nMismatched++;
        $display("FAIL reset_mid_lw cycle %0d got %h, expected %h", i, obs0, ex[i]);
      end
      @(posedge clk); #1;
    end
    // After release and one stalled FETCH, the fetch completes normally
    mem_ready = 1'b1;
    #3;
    nCompared++;
    if (obs0 !== E_FETCH) begin
      nMismatched++; $display("FAIL reset_refetch got %h, expected %h", obs0, E_FETCH);
    end
  endtask

  initial begin
    reset = 1'b1; Op = 6'h00; mem_ready = 1'b0;
    test_reset();
    test_rtype_fetch_stall();
    test_lw_stall();
    test_back_to_back();
    test_illegal();
    test_jump();
    test_reset_mid_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
